// File: rtl/binary_quiz_controller.sv
// Round controller for the DIP-switch binary counting game: LFSR target, debounced answer/submit, scoring.
// Optional build macro BINARY_QUIZ_PENALTY_EN: a wrong answer also decrements the score (saturating at 0).
module binary_quiz_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FEEDBACK_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       submit,
  output logic [3:0] digit,
  output logic       correct,
  output logic       wrong,
  output logic [7:0] score
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FBW = $clog2(FEEDBACK_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FBW-1:0] FB_LAST = FBW'(FEEDBACK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_PLAY     = 2'd1,
    ST_FEEDBACK = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'h01;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'h00) ? v : v - 8'h01;
  endfunction

  logic [3:0]     r_sw_s1, r_sw_s2, r_sw_db;
  logic [DBW-1:0] r_sw_cnt;
  logic           r_sub_s1, r_sub_s2, r_sub_db, r_sub_db_d;
  logic [DBW-1:0] r_sub_cnt;
  logic [7:0]     r_lfsr;
  state_t         r_state, w_state_nxt;
  logic [FBW-1:0] r_fb_cnt;
  logic [3:0]     r_target;
  logic [7:0]     r_score;
  logic           r_correct, r_wrong;
  logic           w_correct_nxt, w_wrong_nxt;
  logic           w_press, w_match;

  // Switch synchronizer and debounce; s1 is the next synchronized value, so a pending change restarts the count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sw_s1  <= 4'h0;
      r_sw_s2  <= 4'h0;
      r_sw_db  <= 4'h0;
      r_sw_cnt <= {DBW{1'b0}};
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      if (r_sw_cnt == DB_LAST && r_sw_s2 != r_sw_db) begin
        r_sw_db  <= r_sw_s2;
        r_sw_cnt <= {DBW{1'b0}};
      end else if (r_sw_s1 != r_sw_s2 || r_sw_s2 == r_sw_db) begin
        r_sw_cnt <= {DBW{1'b0}};
      end else begin
        r_sw_cnt <= r_sw_cnt + 1'b1;
      end
    end
  end

  // Submit synchronizer, debounce and edge history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sub_s1   <= 1'b0;
      r_sub_s2   <= 1'b0;
      r_sub_db   <= 1'b0;
      r_sub_db_d <= 1'b0;
      r_sub_cnt  <= {DBW{1'b0}};
    end else begin
      r_sub_s1   <= submit;
      r_sub_s2   <= r_sub_s1;
      r_sub_db_d <= r_sub_db;
      if (r_sub_cnt == DB_LAST && r_sub_s2 != r_sub_db) begin
        r_sub_db  <= r_sub_s2;
        r_sub_cnt <= {DBW{1'b0}};
      end else if (r_sub_s1 != r_sub_s2 || r_sub_s2 == r_sub_db) begin
        r_sub_cnt <= {DBW{1'b0}};
      end else begin
        r_sub_cnt <= r_sub_cnt + 1'b1;
      end
    end
  end

  assign w_press = r_sub_db & ~r_sub_db_d;
  assign w_match = (r_sw_db == r_target);

  // Free-running LFSR, x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  // FSM state register with registered indication outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_LOAD;
      r_correct <= 1'b0;
      r_wrong   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_correct <= w_correct_nxt;
      r_wrong   <= w_wrong_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:     w_state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (w_press) w_state_nxt = ST_FEEDBACK;
        else         w_state_nxt = ST_PLAY;
      end
      ST_FEEDBACK: begin
        if (r_fb_cnt == FB_LAST) w_state_nxt = ST_LOAD;
        else                     w_state_nxt = ST_FEEDBACK;
      end
      default:     w_state_nxt = ST_LOAD;
    endcase
  end

  // FSM output logic: next values of the correct/wrong indication
  always_comb begin
    w_correct_nxt = 1'b0;
    w_wrong_nxt   = 1'b0;
    case (r_state)
      ST_PLAY: begin
        if (w_press) begin
          w_correct_nxt = w_match;
          w_wrong_nxt   = ~w_match;
        end else begin
          w_correct_nxt = 1'b0;
          w_wrong_nxt   = 1'b0;
        end
      end
      ST_FEEDBACK: begin
        if (r_fb_cnt == FB_LAST) begin
          w_correct_nxt = 1'b0;
          w_wrong_nxt   = 1'b0;
        end else begin
          w_correct_nxt = r_correct;
          w_wrong_nxt   = r_wrong;
        end
      end
      default: begin
        w_correct_nxt = 1'b0;
        w_wrong_nxt   = 1'b0;
      end
    endcase
  end

  // Round datapath: target capture, feedback timer and score
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_target <= 4'h0;
      r_score  <= 8'h00;
      r_fb_cnt <= {FBW{1'b0}};
    end else begin
      if (r_state == ST_FEEDBACK) begin
        r_fb_cnt <= r_fb_cnt + 1'b1;
      end else begin
        r_fb_cnt <= {FBW{1'b0}};
      end
      if (r_state == ST_LOAD) begin
        r_target <= r_lfsr[3:0];
      end
      if (r_state == ST_PLAY && w_press) begin
        if (w_match) begin
          r_score <= sat_inc(r_score);
        end else begin
`ifdef BINARY_QUIZ_PENALTY_EN
          r_score <= sat_dec(r_score);
`else
          r_score <= r_score;
`endif
        end
      end
    end
  end

  assign digit   = r_target;
  assign correct = r_correct;
  assign wrong   = r_wrong;
  assign score   = r_score;

endmodule

// File: tb/tb_binary_quiz_controller.sv
// Self-checking bench for binary_quiz_controller: per-cycle behavioural model plus directed literal checks.
module tb_binary_quiz_controller;
  localparam int D = 4;
  localparam int F = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       submit = 1'b0;
  logic [3:0] digit;
  logic       correct, wrong;
  logic [7:0] score;

  binary_quiz_controller #(.DEBOUNCE_CYCLES(D), .FEEDBACK_CYCLES(F)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .submit(submit),
    .digit(digit), .correct(correct), .wrong(wrong), .score(score)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: raw sample histories (index 0 = latest edge) and the game view of a round
  logic [3:0] q_sw[$];
  bit         q_sub[$];
  bit         m_valid = 1'b0;
  logic [3:0] m_db_sw;
  bit         m_db_sub, m_db_sub_old;
  int         m_phase;      // 0 load, 1 play, 2 feedback
  int         m_fb_left;
  logic [3:0] m_target;
  int         m_score;
  bit         m_correct, m_wrong;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pulse;
    logic [3:0] sw_seen;
    bit sw_win, sub_win;
    if (!rst_n) begin
      q_sw.delete();
      q_sub.delete();
      for (int i = 0; i <= D; i++) begin
        q_sw.push_back(4'h0);
        q_sub.push_back(1'b0);
      end
      m_db_sw = 4'h0; m_db_sub = 1'b0; m_db_sub_old = 1'b0;
      m_phase = 0; m_fb_left = 0; m_target = 4'h0; m_score = 0;
      m_correct = 1'b0; m_wrong = 1'b0; m_lfsr = 8'hA5;
      m_valid = 1'b1;
      return;
    end
    pulse = m_db_sub && !m_db_sub_old;
    sw_seen = m_db_sw;
    m_db_sub_old = m_db_sub;
    // A value is accepted once it was sampled on D consecutive edges ending two edges ago
    sw_win = 1'b1;
    sub_win = 1'b1;
    for (int i = 1; i <= D; i++) begin
      if (q_sw[i] != q_sw[1]) sw_win = 1'b0;
      if (q_sub[i] != q_sub[1]) sub_win = 1'b0;
    end
    if (sw_win) m_db_sw = q_sw[1];
    if (sub_win) m_db_sub = q_sub[1];
    q_sw.push_front(sw);
    q_sub.push_front(submit);
    void'(q_sw.pop_back());
    void'(q_sub.pop_back());
    case (m_phase)
      0: begin
        m_target = m_lfsr[3:0];
        m_phase = 1;
      end
      1: begin
        if (pulse) begin
          m_phase = 2;
          m_fb_left = F;
          if (sw_seen == m_target) begin
            m_correct = 1'b1;
            if (m_score < 255) m_score++;
          end else begin
            m_wrong = 1'b1;
`ifdef BINARY_QUIZ_PENALTY_EN
            if (m_score > 0) m_score--;
`endif
          end
        end
      end
      default: begin
        m_fb_left--;
        if (m_fb_left == 0) begin
          m_phase = 0;
          m_correct = 1'b0;
          m_wrong = 1'b0;
        end
      end
    endcase
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("digit", digit, m_target);
      chk("correct", correct, m_correct);
      chk("wrong", wrong, m_wrong);
      chk("score", score, m_score);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int n = 0;
    while (m_phase != ph && n < budget) begin
      tick(1);
      n++;
    end
    if (m_phase != ph) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_phase: phase %0d not reached, still %0d", ph, m_phase);
    end
  endtask

  task automatic correct_round();
    submit = 1'b0;
    tick(D + 3);
    wait_phase(1, 200);
    sw = m_target;
    tick(D + 3);
    submit = 1'b1;
    tick(D + 4);
    submit = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("first_digit", digit, 32'd5);
    chk("first_score", score, 32'd0);
    chk("first_ind", {correct, wrong}, 32'd0);

    // Correct answer: result exactly at edge 7 after submit is raised
    sw = 4'b0101;
    tick(D + 4);
    submit = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      if (k == 6) chk("correct_early", correct, 32'd0);
      if (k == 7) begin
        chk("correct_edge7", correct, 32'd1);
        chk("score_after_1", score, 32'd1);
      end
    end
    n = 0;
    while (correct === 1'b1 && n < 100) begin
      n++;
      tick(1);
    end
    chk("correct_len", n, F);

    // Submit still held into the next PLAY: no new result
    tick(12);
    chk("held_no_result", {correct, wrong}, 32'd0);

    // Wrong answer, then a press during feedback that must be ignored
    submit = 1'b0;
    tick(D + 3);
    sw = ~m_target;
    tick(D + 3);
    submit = 1'b1;
    tick(D + 4);
    chk("wrong_set", wrong, 32'd1);
`ifdef BINARY_QUIZ_PENALTY_EN
    chk("wrong_score", score, 32'd0);
`else
    chk("wrong_score", score, 32'd1);
`endif
    submit = 1'b0;
    tick(D + 3);
    submit = 1'b1;
    tick(D + 3);
    submit = 1'b0;
    wait_phase(1, 100);
    tick(5);
    chk("fb_press_ignored", {correct, wrong}, 32'd0);

    // Bounce rejection followed by one clean press
    submit = 1'b1; tick(3);
    submit = 1'b0; tick(3);
    submit = 1'b1; tick(2);
    submit = 1'b0; tick(10);
    chk("bounce_ignored", {correct, wrong}, 32'd0);
    submit = 1'b1; tick(4);
    submit = 1'b0; tick(D + 4);
    chk("clean_press", {1'b0, correct | wrong}, 32'd1);
    wait_phase(1, 100);

    // Randomized segments on both raw inputs
    for (int s = 0; s < 300; s++) begin
      submit = 1'($urandom_range(0, 1));
      sw = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : m_target;
      tick($urandom_range(1, 2 * D));
    end

    // Saturation
    for (int r = 0; r < 256; r++) correct_round();
    chk("score_sat", score, 32'd255);
    correct_round();
    chk("score_sat_hold", score, 32'd255);

    // Reset in the middle of feedback
    correct_round();
    tick(5);
    rst_n = 1'b0;
    tick(1);
    chk("rst_score", score, 32'd0);
    chk("rst_correct", correct, 32'd0);
    chk("rst_digit", digit, 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk("rst_digit_reload", digit, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/binary_quiz_controller.md
# binary_quiz_controller

Game-round controller for the DIP-switch binary counting game. Each round it picks a pseudo-random 4-bit target, drives it as the hex digit feeding the seven-segment decoder, and reads the player's answer from debounced DIP switches on a debounced submit press. It scores correct answers and shows a timed correct/wrong indication. It sits between the raw `ui_in` pins and the `sevenseg_decoder` digit input in the top level.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a synchronized input is accepted; minimum 2.
- `FEEDBACK_CYCLES`, 32: duration of the correct/wrong indication; minimum 1.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `sw` in 4: raw DIP switches, asynchronous; bit 3 is the MSB of the answer.
- `submit` in 1: raw submit button, active-high, asynchronous.
- `digit` out 4: target digit driven to the seven-segment decoder.
- `correct` out 1: high for the whole FEEDBACK state after a matching answer.
- `wrong` out 1: high for the whole FEEDBACK state after a mismatching answer.
- `score` out 8: count of correct answers.

## Operation
- **Synchronizers.** `sw` and `submit` each pass through 2 flops.
- **Debounce, one unit per input.** `sw` is one 4-bit unit; `submit` is a second unit.
  - The stability counter clears whenever the synchronized value differs from its previous-cycle value, or equals the debounced value.
  - Otherwise the counter increments.
  - When the counter is at `DEBOUNCE_CYCLES-1` and the synchronized value still differs from the debounced value, the debounced value takes the synchronized value and the counter clears.
  - Debounced values reset to 0.
- **Press pulse.** One cycle long, generated on the rising edge of the debounced submit (debounced high AND previous debounced low). Holding the button produces exactly one pulse.
- **LFSR.** 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Reset seed is 8'hA5. It shifts every cycle in every state and never reaches 0.
- **FSM states:**
  - LOAD: `target <= lfsr[3:0]` (pre-shift value); go to PLAY next cycle.
  - PLAY: wait for a press pulse. On a pulse, compare debounced `sw` with `target` and go to FEEDBACK.
    - Match: `correct` high, `score` +1, saturating at 255.
    - Mismatch: `wrong` high, `score` unchanged.
  - FEEDBACK: hold the indication for `FEEDBACK_CYCLES` cycles, then go to LOAD. `correct` and `wrong` are low in every other state.
- **Press pulses in LOAD or FEEDBACK** are discarded. A press already in progress does not carry into PLAY.
- **`digit`** equals `target` in every state. The player sees the finished round's target during feedback.
- **Reset values:**
  - FSM state = LOAD.
  - `target` = 0, so `digit` = 0.
  - `score` = 0; `correct` = `wrong` = 0.
  - LFSR = 8'hA5; counters and synchronizers = 0.

## Timing
- The first clock after `rst_n` rises executes LOAD. `digit` = 4'h5 (from 8'hA5) from the next cycle on.
- **Raw input to debounced value.** Count from the first edge that samples the new raw value; that edge is edge 1. The debounced value updates at edge `DEBOUNCE_CYCLES+2`, provided the raw value is held.
- **Press to result.** The press pulse is combinational from the debounced value. `correct`/`wrong`/`score` update at edge `DEBOUNCE_CYCLES+3`.
- **Switch timing.** A switch change must settle debounced before that edge to be counted. Debounced `sw` is sampled in the same cycle as the press pulse.
- **Round length.** FEEDBACK is exactly `FEEDBACK_CYCLES` cycles, then 1 LOAD cycle, then PLAY.
- **Glitches.** A raw glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles never changes the debounced value.
- **Reset mid-round.** Reset in any state returns all reset values at the next edge; the indication and score are lost.
- **Score overflow.** A correct answer with `score` = 255 leaves it at 255.

## Configuration
- `BINARY_QUIZ_PENALTY_EN` defined:
  - A mismatch decrements `score`, saturating at 0.
  - A correct answer still adds 1.
- Macro not defined:
  - A mismatch leaves `score` unchanged.
- All other behaviour is identical in both builds.

## Test plan
- **Reset and first round.** Release `rst_n`; wait 2 cycles -> `digit` = 4'h5, `score` = 0, `correct` = `wrong` = 0.
- **Correct answer.** With `DEBOUNCE_CYCLES`=4, set `sw` = 4'b0101 and let it settle, then hold `submit` high -> at edge 7 `correct` = 1 and `score` = 1. `correct` stays high exactly 32 cycles, then a new `digit` equals `lfsr[3:0]` at LOAD.
- **Wrong answer.** Set `sw` = 4'b0000 on a target of 5 and press -> `wrong` high for 32 cycles.
  - Without the macro: `score` unchanged.
  - With `BINARY_QUIZ_PENALTY_EN`: `score` decrements, staying at 0 if already 0.
- **Bounce rejection.** Pulse `submit` high 3 cycles, low 3, high 2, with `DEBOUNCE_CYCLES`=4 -> no press pulse and no FSM change. A clean 4-cycle hold then -> exactly one result.
- **Held and early presses.** Press during FEEDBACK -> ignored. Keep `submit` held into the next PLAY -> no result until release and a fresh press.
- **Saturation and reset.** Force 255 correct rounds -> `score` = 255 after a 256th correct. Assert `rst_n` low mid-FEEDBACK -> next edge `score` = 0, `correct` = 0, `digit` = 0.
